// File: rtl/led_sequencer.sv
// LED pattern sequencer: Wishbone-loaded pattern entries stepped through by a tick-prescaled FSM.
// Optional LEDSEQ_PWM_EN adds a CTRL[27:24] brightness PWM on o_led (off: o_led is the loaded value).
module led_sequencer #(
   parameter int NLEDS   = 8,
   parameter int LGSTEPS = 4
) (
   input  logic               i_clk,
   input  logic               i_reset_n,
   input  logic               i_wb_cyc,
   input  logic               i_wb_stb,
   input  logic               i_wb_we,
   input  logic [LGSTEPS:0]   i_wb_addr,
   input  logic [31:0]        i_wb_data,
   input  logic [3:0]         i_wb_sel,
   output logic               o_wb_stall,
   output logic               o_wb_ack,
   output logic [31:0]        o_wb_data,
   output logic [NLEDS-1:0]   o_led,
   output logic               o_active,
   output logic               o_int
);
   localparam logic [1:0]  S_IDLE = 2'd0;
   localparam logic [1:0]  S_LOAD = 2'd1;
   localparam logic [1:0]  S_HOLD = 2'd2;
   localparam logic [31:0] ENTRY_MASK = {16'hFFFF, 16'((32'd1 << NLEDS) - 32'd1)};

   logic [31:0]        mem_q [2**LGSTEPS];
   logic [1:0]         state_q, state_d;
   logic [LGSTEPS-1:0] idx_q, idx_d, last_q;
   logic [15:0]        hold_q, hold_d;
   logic [23:0]        pre_q, pre_d, p_q;
   logic [NLEDS-1:0]   led_q, led_d;
   logic               int_q, int_d, done_q, loop_q, ack_q;
   logic [31:0]        rdat_q, rdat_d, ctrl_rd;
   logic               acc, wr, ctrl_wr, pre_wr, ent_wr, start, stop;
   logic [3:0]         bright;

   assign acc     = i_wb_cyc & i_wb_stb;
   assign wr      = acc & i_wb_we & (&i_wb_sel);
   assign ent_wr  = wr & i_wb_addr[LGSTEPS];
   assign ctrl_wr = wr & ~i_wb_addr[LGSTEPS] & (i_wb_addr[LGSTEPS-1:0] == '0);
   assign pre_wr  = wr & ~i_wb_addr[LGSTEPS] & (i_wb_addr[LGSTEPS-1:0] == LGSTEPS'(1));
   assign start   = ctrl_wr & i_wb_data[0] & ~i_wb_data[1];
   assign stop    = ctrl_wr & i_wb_data[1];

   // Pattern storage is deliberately not reset.
   always_ff @(posedge i_clk) begin
      if (ent_wr)
         mem_q[i_wb_addr[LGSTEPS-1:0]] <= i_wb_data & ENTRY_MASK;
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      hold_d  = hold_q;
      pre_d   = pre_q;
      led_d   = led_q;
      int_d   = 1'b0;
      case (state_q)
         S_IDLE: state_d = S_IDLE;
         S_LOAD: begin
            led_d   = mem_q[idx_q][NLEDS-1:0];
            hold_d  = mem_q[idx_q][31:16];
            pre_d   = p_q;
            state_d = S_HOLD;
         end
         S_HOLD: begin
            if (pre_q == '0) begin
               pre_d = p_q;
               if (hold_q == '0) begin
                  if (idx_q != last_q) begin
                     idx_d   = idx_q + LGSTEPS'(1);
                     state_d = S_LOAD;
                  end else if (loop_q) begin
                     idx_d   = '0;
                     state_d = S_LOAD;
                  end else begin
                     state_d = S_IDLE;
                     int_d   = 1'b1;
                  end
               end else begin
                  hold_d = hold_q - 16'd1;
               end
            end else begin
               pre_d = pre_q - 24'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Software commands override the FSM; STOP freezes the LEDs where they are.
      if (stop) begin
         state_d = S_IDLE;
         led_d   = led_q;
         int_d   = 1'b0;
      end else if (start) begin
         state_d = S_LOAD;
         idx_d   = '0;
         int_d   = 1'b0;
      end
   end

   assign ctrl_rd = {o_active, done_q, 2'b00, bright, 4'h0, 4'(idx_q), 4'h0, 4'(last_q),
                     5'b00000, loop_q, 2'b00};

   always_comb begin
      rdat_d = 32'h0;
      if (i_wb_addr[LGSTEPS])
         rdat_d = mem_q[i_wb_addr[LGSTEPS-1:0]];
      else if (i_wb_addr[LGSTEPS-1:0] == '0)
         rdat_d = ctrl_rd;
      else if (i_wb_addr[LGSTEPS-1:0] == LGSTEPS'(1))
         rdat_d = {8'h00, p_q};
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         hold_q  <= '0;
         pre_q   <= '0;
         led_q   <= '0;
         int_q   <= 1'b0;
         done_q  <= 1'b0;
         loop_q  <= 1'b0;
         last_q  <= '0;
         p_q     <= '0;
         ack_q   <= 1'b0;
         rdat_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         hold_q  <= hold_d;
         pre_q   <= pre_d;
         led_q   <= led_d;
         int_q   <= int_d;
         ack_q   <= acc;
         if (acc)
            rdat_q <= rdat_d;
         if (int_d)
            done_q <= 1'b1;
         else if (ctrl_wr && i_wb_data[30])
            done_q <= 1'b0;
         if (ctrl_wr) begin
            loop_q <= i_wb_data[2];
            last_q <= i_wb_data[8 +: LGSTEPS];
         end
         if (pre_wr)
            p_q <= i_wb_data[23:0];
      end
   end

`ifdef LEDSEQ_PWM_EN
   logic [3:0] bright_q, pwm_q;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         bright_q <= 4'hF;
         pwm_q    <= 4'h0;
      end else begin
         if (ctrl_wr)
            bright_q <= i_wb_data[27:24];
         pwm_q <= (pwm_q == 4'd14) ? 4'h0 : pwm_q + 4'd1;
      end
   end

   // Counter spans 0..14, so B=15 is always on and B=0 always off.
   assign bright = bright_q;
   assign o_led  = led_q & {NLEDS{pwm_q < bright_q}};
`else
   assign bright = 4'h0;
   assign o_led  = led_q;
`endif

   assign o_wb_stall = 1'b0;
   assign o_wb_ack   = ack_q;
   assign o_wb_data  = rdat_q;
   assign o_active   = (state_q != S_IDLE);
   assign o_int      = int_q;
endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer: directed register checks plus randomized sequences
// compared sample-by-sample against an arithmetic schedule model.
module tb_led_sequencer;
   localparam int NLEDS = 8;
   localparam int LGSTEPS = 4;
`ifdef LEDSEQ_PWM_EN
   localparam logic [31:0] B_FULL = 32'h0F00_0000;
`else
   localparam logic [31:0] B_FULL = 32'h0000_0000;
`endif
   localparam logic [4:0] A_CTRL = 5'b0_0000;
   localparam logic [4:0] A_PRE  = 5'b0_0001;

   logic i_clk = 1'b0, i_reset_n = 1'b0, cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [LGSTEPS:0] addr = '0;
   logic [31:0] wdat = '0;
   logic [3:0] sel = '0;
   logic o_wb_stall, o_wb_ack, o_active, o_int;
   logic [31:0] o_wb_data;
   logic [NLEDS-1:0] o_led;

   led_sequencer #(.NLEDS(NLEDS), .LGSTEPS(LGSTEPS)) dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
      .i_wb_addr(addr), .i_wb_data(wdat), .i_wb_sel(sel), .o_wb_stall(o_wb_stall),
      .o_wb_ack(o_wb_ack), .o_wb_data(o_wb_data), .o_led(o_led), .o_active(o_active),
      .o_int(o_int));

   always #5 i_clk = ~i_clk;

   int n_tests = 0, n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting posedge.
   task automatic wb_xfer(input logic w, input logic [4:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd);
      cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdat = d; sel = s;
      @(negedge i_clk);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      check("wb_ack", o_wb_ack, 1);
      rd = o_wb_data;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      logic [31:0] dummy;
      wb_xfer(1'b1, a, d, 4'hF, dummy);
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] v);
      wb_xfer(1'b0, a, 32'h0, 4'hF, v);
   endtask

   function automatic logic [4:0] ent(input int k);
      return {1'b1, 4'(k)};
   endfunction

   // Reference model: each visited entry shows its LED value for 1+(H+1)*(P+1) samples.
   typedef struct packed {logic intr; logic act; logic [7:0] led;} samp_t;
   samp_t exp_q[$];
   logic [7:0] m_led [16];
   int m_h [16];
   int m_p, m_last;
   bit m_loop;
   logic [7:0] m_now = 8'h00;

   function automatic logic [31:0] ctrl_word(input bit go, input bit halt);
      return B_FULL | (32'(m_last) << 8) | (32'(m_loop) << 2) | (32'(halt) << 1) | 32'(go);
   endfunction

   task automatic program_seq(input int p, input int last, input bit loop);
      m_p = p; m_last = last; m_loop = loop;
      for (int k = 0; k <= last; k++)
         wr(ent(k), {16'(m_h[k]), 8'h00, m_led[k]});
      wr(A_PRE, 32'(p));
      wr(A_CTRL, ctrl_word(1'b0, 1'b0) | 32'h4000_0000);
   endtask

   task automatic build_expect(input int max_samp);
      int i, d;
      bit fin;
      exp_q.delete();
      exp_q.push_back(samp_t'({1'b0, 1'b1, m_now}));
      i = 0;
      while (exp_q.size() < max_samp) begin
         d = 1 + (m_h[i] + 1) * (m_p + 1);
         for (int k = 1; k <= d; k++) begin
            fin = !m_loop && (i == m_last) && (k == d);
            exp_q.push_back(samp_t'({fin, !fin, m_led[i]}));
         end
         if (i == m_last) begin
            if (!m_loop) break;
            i = 0;
         end else begin
            i++;
         end
      end
      if (!m_loop)
         repeat (3) exp_q.push_back(samp_t'({1'b0, 1'b0, m_led[m_last]}));
      while (exp_q.size() > max_samp) void'(exp_q.pop_back());
      m_now = exp_q[exp_q.size()-1].led;
   endtask

   // START then compare every sample; looping runs are stopped afterwards.
   task automatic run_case(input string tag, input int max_samp);
      logic [31:0] v;
      build_expect(max_samp);
      wr(A_CTRL, ctrl_word(1'b1, 1'b0));
      for (int j = 0; j < exp_q.size(); j++) begin
         if (j > 0) @(negedge i_clk);
         check($sformatf("%s_led%0d", tag, j), o_led, exp_q[j].led);
         check($sformatf("%s_act%0d", tag, j), o_active, exp_q[j].act);
         check($sformatf("%s_int%0d", tag, j), o_int, exp_q[j].intr);
      end
      if (m_loop) begin
         wr(A_CTRL, ctrl_word(1'b0, 1'b1));
         check({tag, "_stop_act"}, o_active, 0);
         check({tag, "_stop_int"}, o_int, 0);
         check({tag, "_stop_led"}, o_led, m_now);
         rd(A_CTRL, v);
         check({tag, "_stop_done"}, v[31:30], 2'b00);
      end else begin
         rd(A_CTRL, v);
         check({tag, "_ctrl"}, v, B_FULL | 32'h4000_0000 | (32'(m_last) << 16) | (32'(m_last) << 8));
      end
   endtask

   initial begin
      logic [31:0] v;
      int cnt;
      repeat (2) @(negedge i_clk);
      i_reset_n = 1'b1;
      @(negedge i_clk);
      check("rst_led", o_led, 0);
      check("rst_act", o_active, 0);
      check("rst_int", o_int, 0);
      check("rst_ack", o_wb_ack, 0);
      check("rst_rdat", o_wb_data, 0);
      rd(A_CTRL, v); check("rst_ctrl", v, B_FULL);
      rd(A_PRE, v);  check("rst_pre", v, 0);

      wr(A_PRE, 32'hFFFF_FFFF);
      rd(A_PRE, v); check("pre_mask", v, 32'h00FF_FFFF);
      wb_xfer(1'b1, A_PRE, 32'h0000_0005, 4'h7, v);
      rd(A_PRE, v); check("pre_partial_sel", v, 32'h00FF_FFFF);
      wr(ent(15), 32'hFFFF_FFFF);
      rd(ent(15), v); check("entry_mask", v, 32'hFFFF_00FF);
      wr(A_CTRL, 32'h4F00_0000 | B_FULL);
      rd(A_CTRL, v); check("ctrl_bright", v, B_FULL);

      // Directed one-shot and looping pattern.
      m_led[0] = 8'h81; m_h[0] = 1;
      m_led[1] = 8'h18; m_h[1] = 0;
      program_seq(3, 1, 1'b0);
      run_case("oneshot", 1000);
      program_seq(3, 1, 1'b1);
      run_case("loop", 1 + 3 * 14);
      cnt = 0;
      repeat (20) begin
         @(negedge i_clk);
         if (o_int || o_active || o_led != m_now) cnt++;
      end
      check("post_stop_quiet", cnt, 0);

      // Restart while at index 1, then combined START|STOP.
      program_seq(3, 1, 1'b0);
      wr(A_CTRL, ctrl_word(1'b1, 1'b0));
      repeat (11) @(negedge i_clk);
      check("restart_pre_led", o_led, 8'h18);
      wr(A_CTRL, ctrl_word(1'b1, 1'b0));
      check("restart_act", o_active, 1);
      @(negedge i_clk);
      check("restart_led", o_led, 8'h81);
      wr(A_CTRL, ctrl_word(1'b1, 1'b1));
      check("startstop_act", o_active, 0);
      check("startstop_led", o_led, 8'h81);

      // Reset in the middle of a hold.
      wr(A_CTRL, ctrl_word(1'b1, 1'b0));
      repeat (4) @(negedge i_clk);
      i_reset_n = 1'b0;
      #1;
      check("midrst_led", o_led, 0);
      check("midrst_act", o_active, 0);
      check("midrst_int", o_int, 0);
      @(negedge i_clk);
      i_reset_n = 1'b1;
      cnt = 0;
      repeat (40) begin
         @(negedge i_clk);
         if (o_int || o_active) cnt++;
      end
      check("midrst_quiet", cnt, 0);
      rd(A_PRE, v); check("midrst_pre", v, 0);
      m_now = 8'h00;

      // Randomized sequences, alternating one-shot and looping.
      for (int r = 0; r < 6; r++) begin
         for (int k = 0; k < 16; k++) begin
            m_led[k] = 8'($urandom);
            m_h[k] = int'($urandom_range(0, 3));
         end
         program_seq(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), r[0]);
         run_case($sformatf("rand%0d", r), r[0] ? int'($urandom_range(20, 70)) : 1000);
      end

`ifdef LEDSEQ_PWM_EN
      wr(ent(0), 32'hFFFF_00FF);
      wr(A_PRE, 32'h0);
      wr(A_CTRL, 32'h0500_0001);
      repeat (2) @(negedge i_clk);
      cnt = 0;
      repeat (15) begin
         @(negedge i_clk);
         if (o_led == 8'hFF) cnt++;
      end
      check("pwm_b5", cnt, 5);
      wr(A_CTRL, 32'h0000_0000);
      cnt = 0;
      repeat (15) begin
         @(negedge i_clk);
         if (o_led == 8'h00) cnt++;
      end
      check("pwm_b0", cnt, 15);
      wr(A_CTRL, 32'h0F00_0000);
      cnt = 0;
      repeat (15) begin
         @(negedge i_clk);
         if (o_led == 8'hFF) cnt++;
      end
      check("pwm_b15", cnt, 15);
      wr(A_CTRL, 32'h0F00_0002);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
